// File: rtl/piso_pkg.sv
// Shared types and sizing helpers for the parallel-in/serial-out transmitter.
package piso_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } piso_state_e;

    // Bit-counter width; clamped to 1 so a degenerate WIDTH still yields a legal vector.
    function automatic int PISO_CNT_W(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Enabled up-counter with synchronous clear; flags the last bit position of a word.
module piso_bit_counter
    import piso_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic last
);

    localparam int CW = PISO_CNT_W(WIDTH);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign last = (count_q == CW'(WIDTH - 1));

    // Saturates at WIDTH-1: only a fresh load returns the count to zero.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && !last) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/piso_shift_tx.sv
// Serialises a WIDTH-bit word loaded over a valid/ready handshake, one bit per shift_en cycle.
// Handshake: a word transfers on a rising edge where load_valid && load_ready; load_ready is a pure function of state.
module piso_shift_tx
    import piso_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift_en,
    output logic             sout,
    output logic             sout_valid,
    output logic             busy,
    output logic             done,
    output piso_state_e      state_dbg
);

    piso_state_e      state_q;
    piso_state_e      state_d;
    logic [WIDTH-1:0] sreg_q;
    logic [WIDTH-1:0] sreg_d;
    logic             cnt_clr;
    logic             cnt_en;
    logic             cnt_last;
    logic             head;

    piso_bit_counter #(
        .WIDTH(WIDTH)
    ) u_bit_counter (
        .clk  (clk),
        .reset(reset),
        .clr  (cnt_clr),
        .en   (cnt_en),
        .last (cnt_last)
    );

    assign head = MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0];

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        case (state_q)
            IDLE: begin
                if (load_valid) begin
                    sreg_d  = load_data;
                    cnt_clr = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (shift_en) begin
                    sreg_d = MSB_FIRST ? {sreg_q[WIDTH-2:0], 1'b0}
                                       : {1'b0, sreg_q[WIDTH-1:1]};
                    cnt_en = 1'b1;
                    if (cnt_last) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            sreg_q  <= '0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
        end
    end

    // All outputs decode registered state only, so reset clears them without waiting for a clock.
    assign load_ready = (state_q == IDLE);
    assign sout_valid = (state_q == SHIFT);
    assign sout       = sout_valid & head;
    assign busy       = (state_q == SHIFT) || (state_q == DONE);
    assign done       = (state_q == DONE);
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_piso_shift_tx.sv
// Bench for piso_shift_tx: one MSB-first and one LSB-first instance share all stimulus.
module tb_piso_shift_tx;
    import piso_pkg::*;

    localparam int W = 8;

    logic         clk;
    logic         reset;
    logic         load_valid;
    logic [W-1:0] load_data;
    logic         shift_en;

    logic         ready_m, sout_m, svalid_m, busy_m, done_m;
    logic         ready_l, sout_l, svalid_l, busy_l, done_l;
    piso_state_e  st_m, st_l;

    int checks = 0;
    int errors = 0;

    piso_shift_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(ready_m),
        .load_data(load_data), .shift_en(shift_en), .sout(sout_m),
        .sout_valid(svalid_m), .busy(busy_m), .done(done_m), .state_dbg(st_m)
    );

    piso_shift_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(ready_l),
        .load_data(load_data), .shift_en(shift_en), .sout(sout_l),
        .sout_valid(svalid_l), .busy(busy_l), .done(done_l), .state_dbg(st_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: the k-th bit to appear on the line for a given bit order.
    function automatic logic line_bit(input logic [W-1:0] word, input int k, input bit msb);
        int idx;
        idx = msb ? (W - 1 - k) : k;
        return logic'((word >> idx) & 1);
    endfunction

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_ready_m"}, ready_m, 1'b1);
        chk({tag, "_ready_l"}, ready_l, 1'b1);
        chk({tag, "_busy_m"}, busy_m, 1'b0);
        chk({tag, "_busy_l"}, busy_l, 1'b0);
        chk({tag, "_done_m"}, done_m, 1'b0);
        chk({tag, "_done_l"}, done_l, 1'b0);
        chk({tag, "_sout_m"}, sout_m, 1'b0);
        chk({tag, "_sout_l"}, sout_l, 1'b0);
        chk({tag, "_svalid_m"}, svalid_m, 1'b0);
        chk({tag, "_svalid_l"}, svalid_l, 1'b0);
    endtask

    // One complete word. en_mode: 0 = always on, 1 = random with bounded gaps, 2 = 1,0,0 pattern.
    // hold keeps load_valid high with next_word from the handshake onward, so the next call is back-to-back.
    task automatic send_word(input logic [W-1:0] word, input int en_mode,
                             input bit hold, input logic [W-1:0] next_word);
        int   k;
        int   cyc;
        int   gap;
        logic en;
        load_valid = 1'b1;
        load_data  = word;
        shift_en   = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk_idle("pre_load");
        @(posedge clk); #1;
        k   = 0;
        cyc = 0;
        gap = 0;
        while (k < W) begin
            case (en_mode)
                0:       en = 1'b1;
                1:       en = (gap >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
                default: en = ((cyc % 3) == 0);
            endcase
            shift_en = en;
            if (hold) begin
                load_valid = 1'b1;
                load_data  = next_word;
            end else begin
                load_valid = 1'($urandom_range(0, 1));
                load_data  = W'($urandom);
            end
            @(negedge clk);
            chk("shift_sout_m", sout_m, line_bit(word, k, 1'b1));
            chk("shift_sout_l", sout_l, line_bit(word, k, 1'b0));
            chk("shift_svalid_m", svalid_m, 1'b1);
            chk("shift_svalid_l", svalid_l, 1'b1);
            chk("shift_ready_m", ready_m, 1'b0);
            chk("shift_busy_l", busy_l, 1'b1);
            chk("shift_done_m", done_m, 1'b0);
            @(posedge clk); #1;
            if (en) begin
                k++;
                gap = 0;
            end else begin
                gap++;
            end
            cyc++;
        end
        shift_en   = 1'($urandom_range(0, 1));
        load_valid = hold ? 1'b1 : 1'($urandom_range(0, 1));
        load_data  = hold ? next_word : W'($urandom);
        @(negedge clk);
        chk("done_done_m", done_m, 1'b1);
        chk("done_done_l", done_l, 1'b1);
        chk("done_sout_m", sout_m, 1'b0);
        chk("done_svalid_l", svalid_l, 1'b0);
        chk("done_ready_m", ready_m, 1'b0);
        chk("done_ready_l", ready_l, 1'b0);
        chk("done_busy_m", busy_m, 1'b1);
        @(posedge clk); #1;
        load_valid = hold;
        load_data  = next_word;
    endtask

    initial begin
        logic [W-1:0] w;
        logic [W-1:0] w2;
        reset      = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;
        shift_en   = 1'b0;
        repeat (3) @(negedge clk);
        chk_idle("reset");
        reset = 1'b1;
        @(posedge clk); #1;

        send_word(8'hA5, 0, 1'b0, 8'h00);
        send_word(8'h01, 0, 1'b0, 8'h00);
        send_word(8'hC3, 2, 1'b0, 8'h00);

        send_word(8'hFF, 0, 1'b1, 8'h00);
        send_word(8'h00, 0, 1'b0, 8'h00);

        repeat (6) begin
            w = W'($urandom);
            send_word(w, 1, 1'b0, 8'h00);
        end

        w  = 8'h5A;
        w2 = W'($urandom);
        send_word(w, 1, 1'b1, w2);
        send_word(w2, 0, 1'b0, 8'h00);

        // Reset while the 4th bit of 8'hF0 is on the line.
        w          = 8'hF0;
        load_valid = 1'b1;
        load_data  = w;
        @(negedge clk);
        chk_idle("rst_pre_load");
        @(posedge clk); #1;
        load_valid = 1'b0;
        shift_en   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_bit_m", sout_m, line_bit(w, i, 1'b1));
            chk("rst_bit_l", sout_l, line_bit(w, i, 1'b0));
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("rst_bit4_m", sout_m, line_bit(w, 3, 1'b1));
        chk("rst_bit4_svalid", svalid_m, 1'b1);
        #1 reset = 1'b0;
        #1;
        chk_idle("rst_async");
        @(posedge clk); #1;
        chk("rst_no_done_m", done_m, 1'b0);
        chk("rst_no_done_l", done_l, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;

        send_word(8'h81, 0, 1'b0, 8'h00);
        send_word(W'($urandom), 2, 1'b0, 8'h00);

        @(negedge clk);
        chk_idle("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/piso_shift_tx.md
# piso_shift_tx

Parallel-in/serial-out transmitter: accepts a WIDTH-bit word through a valid/ready load handshake, holds it in an enabled shift register, and drives it out one bit per qualified cycle on a serial line. It is the readout end of the team's enabled-storage registers: a word captured in parallel storage is serialised to a single downstream consumer, such as a serial link, LED driver or lab-board output pin. A one-cycle `done` pulse marks the end of each word.

## Interface
Parameters:
- WIDTH, 8, data word width in bits; legal range ≥ 2.
- MSB_FIRST, 1, bit order on the line: 1 sends bit WIDTH-1 first, 0 sends bit 0 first.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low. Port names are `clk` and `reset`, as in the rest of the codebase.
- clk  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset; forces all state to reset values immediately.
- load_valid  in  1  producer has a word on load_data.
- load_ready  out  1  block can accept a word (high only in IDLE).
- load_data  in  WIDTH  word to transmit; sampled only on handshake.
- shift_en  in  1  bit-rate enable; consumer takes the current sout bit on cycles where this is high.
- sout  out  1  serial data bit.
- sout_valid  out  1  sout carries a data bit.
- busy  out  1  high in SHIFT and DONE.
- done  out  1  one-cycle pulse after the last bit is consumed.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE:
  - load_ready=1; sout=0, sout_valid=0.
  - When load_valid && load_ready, capture load_data into the shift register, clear the bit counter, go to SHIFT.
- SHIFT:
  - sout is the current head bit; sout_valid=1; load_ready=0; load_valid is ignored.
  - On each cycle with shift_en=1, the head bit is consumed: shift by one (left if MSB_FIRST, else right, zero-fill) and increment the counter.
  - If shift_en=1 and counter == WIDTH-1, go to DONE instead of staying.
  - With shift_en=0, sout, the register and the counter hold.
- DONE:
  - done=1; sout=0, sout_valid=0, load_ready=0.
  - Unconditionally go to IDLE next cycle.
- Counter width is $clog2(WIDTH); it never exceeds WIDTH-1 and wraps to 0 only on a new load.
- sout and sout_valid are registered or derived only from registered state; no combinational path from load_* to sout.
- load_ready depends only on state; no combinational path from load_valid.

## Timing
- Reset values: state=IDLE, shift register=0, counter=0, sout=0, sout_valid=0, busy=0, done=0, load_ready=1.
- Handshake accepted at edge N: first bit on sout and sout_valid=1 from cycle N+1.
- With shift_en tied high:
  - the last bit is on sout in cycle N+WIDTH;
  - done=1 in cycle N+WIDTH+1;
  - load_ready=1 again in cycle N+WIDTH+2.
- Back-to-back words: minimum period is WIDTH+2 cycles; no load is accepted during SHIFT or DONE.
- shift_en gaps stretch SHIFT by exactly the number of low cycles; bit values are unaffected.
- shift_en is ignored in IDLE and DONE.
- load_valid held high through DONE is accepted in the first IDLE cycle.
- Reset asserted mid-word: outputs take reset values asynchronously; the partial word is discarded, and done does not pulse.
- After reset deasserts, the block is in IDLE with load_ready=1 on the first clock.

## Structure
- Package `piso_pkg` holds:
  - `piso_state_e` enum (IDLE, SHIFT, DONE);
  - the `PISO_CNT_W(width)` helper, i.e. the $clog2 count width.
- One natural sub-module, `piso_bit_counter`: enabled up-counter with synchronous clear, the same async active-low `reset`, and a `last` output (count == WIDTH-1).
- The top holds the FSM and the shift register, with next-state logic in always_comb and state in always_ff with async reset.

## Test plan
- WIDTH=8, MSB_FIRST=1, shift_en=1, load 8'hA5 → sout = 1,0,1,0,0,1,0,1 in cycles N+1..N+8; done in N+9; load_ready in N+10.
- MSB_FIRST=0, load 8'h01, shift_en=1 → sout = 1 then seven 0s; sout_valid high for exactly 8 cycles.
- load 8'hC3 with shift_en pattern 1,0,0,1,… → each bit holds through low cycles; the sequence is still 1,1,0,0,0,0,1,1; done after the 8th consumed bit.
- load_valid held high continuously with words 8'hFF then 8'h00 → the second word is accepted exactly 10 cycles after the first; no bit is lost or duplicated.
- reset pulsed low at the 4th bit of 8'hF0 → sout=0, sout_valid=0 and busy=0 immediately; no done pulse; the next load of 8'h81 transmits correctly.
- load_valid asserted during SHIFT with different data → ignored; the original word completes unchanged.
